riscv_mem_arbiter: RTL
======================

# riscv_mem_arbiter

Arbiter and sequencer for the single-port main memory shared by the RV64 core's instruction-fetch port and data (load/store) port. It accepts one request at a time and grants fetch or data with data-first priority and a starvation guard. It issues the winning access to memory, waits for the response with a timeout, and routes read data or the write acknowledge back to the owning port. It sits between `riscv_core_top_2` and the main memory instance inside `riscv_core_top`.

## Interface
- `XLEN`, 64, data and address width
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch is waiting
- `TIMEOUT`, 16, WAIT cycles before the access is aborted with an error
- `clk`  in  1  core clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req_i`  in  1  fetch request, held until granted
- `if_addr_i`  in  XLEN  fetch byte address
- `if_gnt_o`  out  1  fetch granted this cycle
- `if_rvalid_o`  out  1  fetch response valid, one-cycle pulse
- `if_rdata_o`  out  XLEN  fetch read data
- `d_req_i`  in  1  data request, held until granted
- `d_we_i`  in  1  1 = store, 0 = load
- `d_addr_i`  in  XLEN  data byte address
- `d_wdata_i`  in  XLEN  store data
- `d_be_i`  in  XLEN/8  store byte enables
- `d_gnt_o`  out  1  data granted this cycle
- `d_rvalid_o`  out  1  data response valid (load data or store ack), one-cycle pulse
- `d_rdata_o`  out  XLEN  load data
- `err_o`  out  1  valid with an rvalid pulse when the access timed out
- `mem_req_o`  out  1  memory access strobe, one cycle
- `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_be_o`  out  1/XLEN/XLEN/XLEN/8  registered access attributes
- `mem_rvalid_i`  in  1  memory response
- `mem_rdata_i`  in  XLEN  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - With any request, arbitrate. Data wins unless the starvation counter equals `STARVE_MAX` and `if_req_i` is high, in which case fetch wins.
  - `x_gnt_o` is asserted combinationally for the winner this cycle.
  - Address, we, wdata and be are captured; for fetch, we=0 and be=all ones.
  - The owner bit is latched and the FSM goes to ISSUE.
- **ISSUE:** `mem_req_o`=1 for exactly one cycle, then WAIT.
- **WAIT:**
  - Count cycles.
  - On `mem_rvalid_i`, capture `mem_rdata_i` and go to RESP with err=0.
  - When the count reaches `TIMEOUT` with no response, go to RESP with err=1 and rdata=0.
- **RESP:**
  - Pulse the owner's `rvalid_o`. `rdata_o` and `err_o` are valid alongside it.
  - Return to IDLE.
- **Starvation counter:**
  - Increments on each data grant while `if_req_i`=1.
  - Clears on any fetch grant or when `if_req_i`=0.
  - Saturates at `STARVE_MAX`.
- `mem_rvalid_i` outside WAIT is ignored, including stale responses after a timeout or reset.
- Simultaneous requests with counter < `STARVE_MAX`: data granted, fetch stays pending.
- Unowned port rvalid stays 0. `rdata_o` holds its last value when rvalid is 0.

## Timing
- Grant in cycle N → `mem_req_o` in N+1 → WAIT from N+2.
- `mem_rvalid_i` in cycle M → owner `rvalid_o` in M+1 → next grant possible in M+2.
- With a zero-wait memory (response in N+2), throughput is one access per 4 cycles.
- Reset values: state IDLE, counters 0.
  - All `gnt`, `rvalid`, `err` and `mem_req_o` are 0.
  - `mem_addr_o`, `mem_wdata_o`, `mem_be_o` and `mem_we_o` are 0.
  - `rdata_o` is 0.
- Reset asserted mid-operation aborts the transaction with no response pulse; the pending requester must re-request.

## Structure
- Package `riscv_mem_pkg`:
  - state enum `arb_state_e`
  - owner enum `arb_owner_e` (OWN_IF, OWN_D)
  - request struct (addr, we, wdata, be)
- No sub-module needed. The arbitration function and the starvation counter stay inline.

## Test plan
- Fetch only: `if_addr_i`=0x1000 with the memory returning 0xDEADBEEF0000_0013 after 2 cycles → `if_gnt_o` at N, `mem_req_o` at N+1, `if_rvalid_o` with that data at N+4.
- Store: `d_we_i`=1, addr 0x1000_0008, wdata 0x55, be 0x01 → `mem_we_o`=1 with matching attributes and a `d_rvalid_o` ack. A subsequent load of 0x1000_0008 returns 0x55 in byte 0.
- Contention: both requesting every cycle with `STARVE_MAX`=4 → grant sequence D,D,D,D,IF,D,D,D,D,IF.
- Timeout: memory never responds → owner `rvalid_o` with `err_o`=1 and rdata=0 exactly 16 WAIT cycles after entry; a late `mem_rvalid_i` is ignored.
- Reset mid-WAIT: assert `rst` for 1 cycle → all outputs 0 the next cycle, no rvalid pulse, a new request is granted normally.
- Back-to-back loads: data requests 0x0, 0x8, 0x10 held → grants 4 cycles apart, responses in order to the data port only.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types for the instruction/data memory arbiter.
//   arb_state_e : sequencer states (idle, issue strobe, wait for response, respond)
//   arb_owner_e : which port owns the access in flight
//   mem_req_t   : captured access attributes (addr, we, wdata, be)
package riscv_mem_pkg;

    localparam int MEM_XLEN = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } arb_owner_e;

    typedef struct packed {
        logic [MEM_XLEN-1:0]   addr;
        logic                  we;
        logic [MEM_XLEN-1:0]   wdata;
        logic [MEM_XLEN/8-1:0] be;
    } mem_req_t;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Single-port main-memory arbiter for the RV64 fetch and data ports.
// One access in flight at a time: IDLE arbitrates (data first, fetch after
// STARVE_MAX consecutive data grants while fetch waits), ISSUE strobes the
// memory for one cycle, WAIT collects the response or times out, RESP pulses
// the owning port's rvalid with rdata/err.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req_i/if_addr_i             fetch request (held until granted)
//   if_gnt_o/if_rvalid_o/if_rdata_o fetch grant and response
//   d_req_i/d_we_i/d_addr_i/d_wdata_i/d_be_i   data request
//   d_gnt_o/d_rvalid_o/d_rdata_o   data grant and response
//   err_o                          timeout flag, valid with an rvalid pulse
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o   memory access
//   mem_rvalid_i/mem_rdata_i       memory response
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int XLEN       = MEM_XLEN,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [XLEN-1:0]   if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [XLEN-1:0]   if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [XLEN-1:0]   d_addr_i,
    input  logic [XLEN-1:0]   d_wdata_i,
    input  logic [XLEN/8-1:0] d_be_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [XLEN-1:0]   d_rdata_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_be_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    mem_req_t          req_q, req_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [TW-1:0]     wcnt_q, wcnt_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
    logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
    logic              gnt_if, gnt_d;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        req_d      = req_q;
        starve_d   = starve_q;
        wcnt_d     = wcnt_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        gnt_if     = 1'b0;
        gnt_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Grants are held off during reset so nothing is claimed
                // that the reset is about to discard.
                if (!rst) begin
                    if (d_req_i && !(starve_q == STARVE_SAT && if_req_i)) begin
                        gnt_d = 1'b1;
                    end else if (if_req_i) begin
                        gnt_if = 1'b1;
                    end
                end
                if (gnt_d) begin
                    req_d   = '{addr: d_addr_i, we: d_we_i, wdata: d_wdata_i, be: d_be_i};
                    owner_d = OWN_D;
                    state_d = S_ISSUE;
                end else if (gnt_if) begin
                    req_d   = '{addr: if_addr_i, we: 1'b0, wdata: '0, be: '1};
                    owner_d = OWN_IF;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A response in the last counted cycle still wins over timeout.
                if (mem_rvalid_i) begin
                    err_d = 1'b0;
                    if (owner_q == OWN_D) d_rdata_d = mem_rdata_i;
                    else                  if_rdata_d = mem_rdata_i;
                    state_d = S_RESP;
                end else if (wcnt_q == WAIT_LAST) begin
                    err_d = 1'b1;
                    if (owner_q == OWN_D) d_rdata_d = '0;
                    else                  if_rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Consecutive data grants taken while fetch is waiting.
        if (!if_req_i || gnt_if) begin
            starve_d = '0;
        end else if (gnt_d && starve_q != STARVE_SAT) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_IF;
            req_q      <= '0;
            starve_q   <= '0;
            wcnt_q     <= '0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            req_q      <= req_d;
            starve_q   <= starve_d;
            wcnt_q     <= wcnt_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign if_gnt_o    = gnt_if;
    assign d_gnt_o     = gnt_d;
    assign if_rvalid_o = (state_q == S_RESP) && (owner_q == OWN_IF);
    assign d_rvalid_o  = (state_q == S_RESP) && (owner_q == OWN_D);
    assign err_o       = (state_q == S_RESP) && err_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;

    assign mem_req_o   = (state_q == S_ISSUE);
    assign mem_we_o    = req_q.we;
    assign mem_addr_o  = req_q.addr;
    assign mem_wdata_o = req_q.wdata;
    assign mem_be_o    = req_q.be;

endmodule
